reg_file_sb: RTL
================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero and never busy.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports rd_addr1 and rd_addr2, input, ADDR_W, read port addresses.
REQ-007 SHALL have ports rd_data1 and rd_data2, output, DATA_W, combinational read data.
REQ-008 SHALL have ports rd_busy1 and rd_busy2, output, 1, pending-write flag of the addressed register.
REQ-009 SHALL have ports wr_en (1), wr_addr (ADDR_W) and wr_data (DATA_W), all inputs, writeback port.
REQ-010 SHALL have ports iss_en (1) and iss_addr (ADDR_W), both inputs, issue port that marks a destination register pending.
REQ-011 SHALL have port busy_cnt, output, ADDR_W+1, number of registers currently pending.
REQ-012 SHALL have port dbg_addr, input, ADDR_W, debug read address.
REQ-013 SHALL have port dbg_data, output, DATA_W, registered debug read data.

Function
REQ-014 SHALL write wr_data into RF[wr_addr] at the clock edge when wr_en=1, except when wr_addr=0 and ZERO_REG=1.
REQ-015 SHALL return RF[rd_addrN] combinationally on rd_dataN, and SHALL return 0 for address 0 when ZERO_REG=1.
REQ-016 SHALL bypass: when wr_en=1, wr_addr=rd_addrN and the target is writable, rd_dataN SHALL equal wr_data in the same cycle.
REQ-017 SHALL set busy[iss_addr] at the clock edge when iss_en=1, except for address 0 when ZERO_REG=1.
REQ-018 SHALL clear busy[wr_addr] at the clock edge when wr_en=1.
REQ-019 SHALL apply set-wins when iss_en and wr_en hit the same address in one cycle: the register ends busy and the data is written.
REQ-020 SHALL drive rd_busyN = busy[rd_addrN] AND NOT (wr_en AND wr_addr=rd_addrN); a same-cycle issue SHALL NOT affect rd_busyN until the next cycle.
REQ-021 SHALL leave busy unchanged when iss_en hits an already-busy register, and when wr_en hits a non-busy one.
REQ-022 SHALL update busy_cnt each edge by +1 per newly set bit and -1 per newly cleared bit, net 0 on a set-wins collision.
REQ-023 SHALL keep busy_cnt in the range 0..2**ADDR_W with no wrap.
REQ-024 SHALL register dbg_data <= RF[dbg_addr] with one-cycle latency, using pre-write contents (no bypass).

Reset
REQ-025 SHALL, while rst_n=0 and regardless of clk, clear every RF entry, every busy bit, busy_cnt and dbg_data to 0.
REQ-026 SHALL ignore wr_en and iss_en during reset; a write coincident with rst_n deassertion SHALL NOT be required to take effect.
REQ-027 SHALL force rd_busyN to 0 during reset; a mid-operation reset SHALL discard all pending state.

Structure
REQ-028 SHALL place the default DATA_W/ADDR_W values and a popcount-free delta encoding (+1/0/-1) constant set in shared package mips_pkg.
REQ-029 SHALL implement the busy vector and busy_cnt in one sub-module, reg_scoreboard; the storage array and bypass SHALL stay in reg_file_sb.

Verification
REQ-030 SHALL check: reset, then write 0xDEADBEEF to r5 -> next cycle rd_data1 (rd_addr1=5) = 0xDEADBEEF; dbg_addr=5 -> dbg_data = 0xDEADBEEF one cycle later.
REQ-031 SHALL check: wr_en, wr_addr=7, wr_data=0x12345678 with rd_addr2=7 in the same cycle -> rd_data2 = 0x12345678 combinationally.
REQ-032 SHALL check: write 0xFFFFFFFF to r0 and issue r0 -> rd_data1 = 0, rd_busy1 = 0, busy_cnt = 0.
REQ-033 SHALL check: issue r3, r4 -> busy_cnt = 2, rd_busy r3 = 1; writeback r3 -> rd_busy r3 = 0 in that cycle, busy_cnt = 1 after the edge.
REQ-034 SHALL check: iss_en and wr_en both on r9 (busy) with data 0xA5 -> r9 = 0xA5, still busy, busy_cnt unchanged.
REQ-035 SHALL check: issue all 31 non-zero registers, then assert rst_n=0 mid-clock -> all data, busy bits, busy_cnt and dbg_data read 0 immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared defaults for the register file and the scoreboard's one-hot-free
// busy-count delta encoding.
package mips_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    // Per-edge busy-count change: at most one set and one clear can occur per cycle.
    typedef enum logic [1:0] {
        DELTA_ZERO = 2'b00,
        DELTA_INC  = 2'b01,
        DELTA_DEC  = 2'b11
    } delta_e;

    function automatic delta_e delta_enc(input logic inc, input logic dec);
        if (inc && !dec) return DELTA_INC;
        if (dec && !inc) return DELTA_DEC;
        return DELTA_ZERO;
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Read, writeback, issue and debug signals of the scoreboarded register file.
interface reg_file_sb_if import mips_pkg::*; #(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_busy1;
    logic              rd_busy2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;
    logic [ADDR_W:0]   busy_cnt;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr, dbg_addr,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2, busy_cnt, dbg_data
    );

    modport slave (
        input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr, dbg_addr,
        output rd_data1, rd_data2, rd_busy1, rd_busy2, busy_cnt, dbg_data
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write tracking: one busy bit per register plus a running count of
// set bits, updated incrementally (issue sets, writeback clears, set wins).
module reg_scoreboard import mips_pkg::*; #(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_iss_en,
    input  logic [ADDR_W-1:0] i_iss_addr,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [ADDR_W-1:0] i_rd_addr1,
    input  logic [ADDR_W-1:0] i_rd_addr2,
    output logic              o_rd_busy1,
    output logic              o_rd_busy2,
    output logic [ADDR_W:0]   o_busy_cnt
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DEPTH-1:0] r_busy;
    logic [CNT_W-1:0] r_cnt;

    logic             w_iss_ok;
    logic             w_set_new;
    logic             w_clr_new;
    logic [DEPTH-1:0] w_busy_nxt;
    delta_e           w_delta;

    // Only transitions that actually flip a bit move the count.
    always_comb begin
        w_iss_ok   = i_iss_en && !(ZERO_REG && (i_iss_addr == '0));
        w_set_new  = w_iss_ok && !r_busy[i_iss_addr];
        w_clr_new  = i_wr_en && r_busy[i_wr_addr] &&
                     !(w_iss_ok && (i_iss_addr == i_wr_addr));
        w_busy_nxt = r_busy;
        if (i_wr_en) begin
            w_busy_nxt[i_wr_addr] = 1'b0;
        end
        if (w_iss_ok) begin
            w_busy_nxt[i_iss_addr] = 1'b1;
        end
        w_delta = delta_enc(w_set_new, w_clr_new);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            unique case (w_delta)
                DELTA_INC: if (r_cnt != CNT_W'(DEPTH)) r_cnt <= r_cnt + CNT_W'(1);
                DELTA_DEC: if (r_cnt != '0)            r_cnt <= r_cnt - CNT_W'(1);
                default:   ;
            endcase
        end
    end

    // A same-cycle writeback already resolves the pending value for readers.
    always_comb begin
        o_rd_busy1 = r_busy[i_rd_addr1] && !(i_wr_en && (i_wr_addr == i_rd_addr1));
        o_rd_busy2 = r_busy[i_rd_addr2] && !(i_wr_en && (i_wr_addr == i_rd_addr2));
    end

    assign o_busy_cnt = r_cnt;

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with writeback bypass, registered debug
// read port and a pending-write scoreboard.
module reg_file_sb import mips_pkg::*; #(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    reg_file_sb_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_rf [DEPTH];
    logic [DATA_W-1:0] r_dbg_data;

    logic              w_wr_ok;
    logic [DATA_W-1:0] w_rd_data1;
    logic [DATA_W-1:0] w_rd_data2;
    logic              w_rd_busy1;
    logic              w_rd_busy2;
    logic [ADDR_W:0]   w_busy_cnt;

    // Read mux: array, then same-cycle bypass, then hardwired zero register.
    always_comb begin
        w_wr_ok    = rst_n && bus.wr_en && !(ZERO_REG && (bus.wr_addr == '0));
        w_rd_data1 = r_rf[bus.rd_addr1];
        w_rd_data2 = r_rf[bus.rd_addr2];
        if (w_wr_ok && (bus.wr_addr == bus.rd_addr1)) w_rd_data1 = bus.wr_data;
        if (w_wr_ok && (bus.wr_addr == bus.rd_addr2)) w_rd_data2 = bus.wr_data;
        if (ZERO_REG && (bus.rd_addr1 == '0)) w_rd_data1 = '0;
        if (ZERO_REG && (bus.rd_addr2 == '0)) w_rd_data2 = '0;
    end

    // Debug read samples the array before this edge's write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_rf[ADDR_W'(i)] <= '0;
            end
            r_dbg_data <= '0;
        end else begin
            if (w_wr_ok) begin
                r_rf[bus.wr_addr] <= bus.wr_data;
            end
            r_dbg_data <= r_rf[bus.dbg_addr];
        end
    end

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_iss_en   (bus.iss_en),
        .i_iss_addr (bus.iss_addr),
        .i_wr_en    (bus.wr_en),
        .i_wr_addr  (bus.wr_addr),
        .i_rd_addr1 (bus.rd_addr1),
        .i_rd_addr2 (bus.rd_addr2),
        .o_rd_busy1 (w_rd_busy1),
        .o_rd_busy2 (w_rd_busy2),
        .o_busy_cnt (w_busy_cnt)
    );

    assign bus.rd_data1 = w_rd_data1;
    assign bus.rd_data2 = w_rd_data2;
    assign bus.rd_busy1 = w_rd_busy1;
    assign bus.rd_busy2 = w_rd_busy2;
    assign bus.busy_cnt = w_busy_cnt;
    assign bus.dbg_data = r_dbg_data;

endmodule
